// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard unit.
// Holds the forward-select encoding (register file, EX/MEM lane, MEM/WB lane),
// the hardwired zero register index and the width helpers derived from parameters.
package fwd_pkg;

    localparam int unsigned FWD_RF   = 0;
    localparam int unsigned ZERO_REG = 0;

    // Width of one forward select: RF plus one code per lane per bypass stage.
    function automatic int unsigned calc_fsel_w(input int unsigned lanes);
        return $clog2(2 * lanes + 1);
    endfunction

    // Scoreboard counter width; LOAD_LAT=1 never loads a nonzero value but
    // still needs a one-bit counter to keep the vectors legal.
    function automatic int unsigned calc_cnt_w(input int unsigned load_lat);
        return (load_lat > 1) ? $clog2(load_lat) : 1;
    endfunction

    function automatic int unsigned enc_exmem(input int unsigned lane);
        return 1 + lane;
    endfunction

    function automatic int unsigned enc_memwb(input int unsigned lanes, input int unsigned lane);
        return 1 + lanes + lane;
    endfunction

endpackage

// File: rtl/fwd_sel_lane.sv
// Bypass select for one EX source operand.
// Ports: src_addr/src_used - operand address and read flag;
//        exmem_rd/exmem_we, memwb_rd/memwb_we - per-lane destinations of the bypass stages;
//        sel - forward select (0 = RF, 1+l = EX/MEM lane l, 1+LANES+l = MEM/WB lane l).
module fwd_sel_lane
    import fwd_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned FSEL_W = calc_fsel_w(LANES)
) (
    input  logic [RA_W-1:0]       src_addr,
    input  logic                  src_used,
    input  logic [LANES*RA_W-1:0] exmem_rd,
    input  logic [LANES-1:0]      exmem_we,
    input  logic [LANES*RA_W-1:0] memwb_rd,
    input  logic [LANES-1:0]      memwb_we,
    output logic [FSEL_W-1:0]     sel
);

    // Ascending scans with last-assignment-wins: the younger lane wins within a
    // stage, and the EX/MEM scan runs last so any EX/MEM hit beats MEM/WB.
    always_comb begin
        sel = FSEL_W'(FWD_RF);
        if (src_used && (src_addr != RA_W'(ZERO_REG))) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (memwb_we[l] && (memwb_rd[l*RA_W +: RA_W] == src_addr))
                    sel = FSEL_W'(enc_memwb(LANES, l));
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                if (exmem_we[l] && (exmem_rd[l*RA_W +: RA_W] == src_addr))
                    sel = FSEL_W'(enc_exmem(l));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the multi-issue pipeline.
// Ports: clk, rst_n (async active-low), flush (sync pipeline flush);
//        id_* - ID bundle (sources, destinations, load flags) for the stall decision;
//        ex_src_* - EX operand addresses; exmem_*/memwb_* - bypass stage destinations;
//        fwd_sel - combinational per-source bypass select; stall - combinational ID hold;
//        stall_cnt - registered saturating count of stalled cycles.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned SRCS     = 3,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned LOAD_LAT = 2,
    // Derived from LANES; do not override.
    parameter int unsigned FSEL_W   = calc_fsel_w(LANES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [LANES*SRCS*RA_W-1:0]   id_src_addr,
    input  logic [LANES*SRCS-1:0]        id_src_used,
    input  logic [LANES*RA_W-1:0]        id_dst_addr,
    input  logic [LANES-1:0]             id_dst_we,
    input  logic [LANES-1:0]             id_is_load,
    input  logic [LANES*SRCS*RA_W-1:0]   ex_src_addr,
    input  logic [LANES*SRCS-1:0]        ex_src_used,
    input  logic [LANES*RA_W-1:0]        exmem_rd,
    input  logic [LANES-1:0]             exmem_we,
    input  logic [LANES*RA_W-1:0]        memwb_rd,
    input  logic [LANES-1:0]             memwb_we,
    output logic [LANES*SRCS*FSEL_W-1:0] fwd_sel,
    output logic                         stall,
    output logic [15:0]                  stall_cnt
);

    localparam int unsigned NSRC  = LANES * SRCS;
    localparam int unsigned NREG  = 1 << RA_W;
    localparam int unsigned CNT_W = calc_cnt_w(LOAD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] sb_cnt [NREG];
    logic [CNT_W-1:0] sb_nxt [NREG];
    logic             sb_hit_c;
    logic             issue_c;
    logic [LANES-1:0] ex_load;
    logic [LANES-1:0] exmem_load;
    logic             raw_c;
    logic             exmem_load_sel_c;

    // One priority matcher per EX source operand.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_sel_lane #(
            .LANES  (LANES),
            .RA_W   (RA_W),
            .FSEL_W (FSEL_W)
        ) u_sel (
            .src_addr (ex_src_addr[i*RA_W +: RA_W]),
            .src_used (ex_src_used[i]),
            .exmem_rd (exmem_rd),
            .exmem_we (exmem_we),
            .memwb_rd (memwb_rd),
            .memwb_we (memwb_we),
            .sel      (fwd_sel[i*FSEL_W +: FSEL_W])
        );
    end

    // Any used nonzero ID source whose load result is not yet forwardable.
    always_comb begin
        sb_hit_c = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (id_src_used[i] && (id_src_addr[i*RA_W +: RA_W] != RA_W'(ZERO_REG))
                && (sb_cnt[id_src_addr[i*RA_W +: RA_W]] != '0))
                sb_hit_c = 1'b1;
        end
    end

    assign stall   = id_valid & ~flush & sb_hit_c;
    assign issue_c = id_valid & ~stall & ~flush;

    // Scoreboard next state: count down, then apply issuing lanes in ascending
    // order so the higher lane's rule wins on a shared destination.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++)
            sb_nxt[r] = (sb_cnt[r] != '0) ? sb_cnt[r] - CNT_W'(1) : '0;
        if (flush) begin
            for (int unsigned r = 0; r < NREG; r++)
                sb_nxt[r] = '0;
        end else if (issue_c) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (id_dst_we[l] && (id_dst_addr[l*RA_W +: RA_W] != RA_W'(ZERO_REG)))
                    sb_nxt[id_dst_addr[l*RA_W +: RA_W]] = id_is_load[l] ? CNT_LOAD : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_cnt <= '{default: '0};
        else        sb_cnt <= sb_nxt;
    end

    // Saturating stall counter; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             stall_cnt <= '0;
        else if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end

    // Shadow of which issued lanes are loads as they move through EX and EX/MEM;
    // only used to check that a load is never bypassed from EX/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_load    <= '0;
            exmem_load <= '0;
        end else begin
            ex_load    <= issue_c ? (id_is_load & id_dst_we) : '0;
            exmem_load <= flush ? '0 : ex_load;
        end
    end

    // Intra-bundle RAW: a younger lane reading an older lane's destination.
    always_comb begin
        raw_c = 1'b0;
        for (int unsigned j = 1; j < LANES; j++)
            for (int unsigned s = 0; s < SRCS; s++)
                for (int unsigned i = 0; i < j; i++)
                    if (id_valid && id_src_used[j*SRCS+s] && id_dst_we[i]
                        && (id_src_addr[(j*SRCS+s)*RA_W +: RA_W] != RA_W'(ZERO_REG))
                        && (id_src_addr[(j*SRCS+s)*RA_W +: RA_W] == id_dst_addr[i*RA_W +: RA_W]))
                        raw_c = 1'b1;
    end

    always_comb begin
        exmem_load_sel_c = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++)
            for (int unsigned l = 0; l < LANES; l++)
                if (exmem_load[l] && (fwd_sel[i*FSEL_W +: FSEL_W] == FSEL_W'(enc_exmem(l))))
                    exmem_load_sel_c = 1'b1;
    end

    a_no_intra_raw: assert property (@(posedge clk) disable iff (!rst_n) !raw_c);
    a_no_exmem_load_fwd: assert property (@(posedge clk) disable iff (!rst_n) !exmem_load_sel_c);

endmodule
